// File: rtl/pll_scan_pkg.sv
// Shared types and defaults for the PLL scan-chain reconfiguration loader.
package pll_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WAIT_RECONF,
    ST_UPDATE,
    ST_WAIT_DONE,
    ST_WAIT_LOCK
  } scan_state_e;

  localparam int ADDR_W           = 8;
  localparam int TMO_W            = 8;
  localparam int DEF_SCAN_BITS    = 144;
  localparam int DEF_ROM_LATENCY  = 2;
  localparam int DEF_DONE_TIMEOUT = 255;
  localparam int RECONF_TIMEOUT   = 16;

endpackage

// File: rtl/pll_scan_loader_if.sv
// Config-ROM and PLL scan-port signals seen by the loader (master) and by the ROM/PLL side (slave).
interface pll_scan_loader_if;
  import pll_scan_pkg::*;

  logic [ADDR_W-1:0] rom_address;
  logic              rom_read_ena;
  logic              rom_q;
  logic              rom_reconfig;
  logic              pll_scandata;
  logic              pll_scanclkena;
  logic              pll_configupdate;
  logic              pll_scandone;
  logic              pll_locked;

  modport master (
    output rom_address, rom_read_ena, pll_scandata, pll_scanclkena, pll_configupdate,
    input  rom_q, rom_reconfig, pll_scandone, pll_locked
  );

  modport slave (
    input  rom_address, rom_read_ena, pll_scandata, pll_scanclkena, pll_configupdate,
    output rom_q, rom_reconfig, pll_scandone, pll_locked
  );

endinterface

// File: rtl/pll_scan_loader.sv
// Streams SCAN_BITS config bits from a ROM into a PLL scan chain, then applies
// the update and waits for scandone and lock, flagging a sticky error on timeout.
module pll_scan_loader
  import pll_scan_pkg::*;
#(
  parameter int SCAN_BITS    = DEF_SCAN_BITS,
  parameter int ROM_LATENCY  = DEF_ROM_LATENCY,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  pll_scan_loader_if.master scan,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SCAN_BITS - 1);
  localparam logic [TMO_W-1:0]  RECONF_LAST = TMO_W'(RECONF_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  DONE_LAST   = TMO_W'(DONE_TIMEOUT - 1);

  scan_state_e          state;
  logic [TMO_W-1:0]     tmo;
  logic                 reconf_lat;
  logic                 scandone_q;
  logic [ROM_LATENCY:0] vld_p;
  logic                 data_p0;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + TMO_W'(1);
  endfunction

  // ROM read-enable delay line and registered ROM data: stage ROM_LATENCY
  // lines up with the bit fetched ROM_LATENCY+1 cycles earlier.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p      <= '0;
      data_p0    <= 1'b0;
      scandone_q <= 1'b0;
    end else begin
      vld_p[0] <= scan.rom_read_ena;
      for (int i = 1; i <= ROM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      data_p0    <= scan.rom_q;
      scandone_q <= scan.pll_scandone;
    end
  end

  assign scan.pll_scanclkena = vld_p[ROM_LATENCY];
  assign scan.pll_scandata   = data_p0;
  assign busy                = (state != ST_IDLE);

  // Every transition below also clears tmo, so it always counts cycles in the current state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_IDLE;
      tmo                   <= '0;
      reconf_lat            <= 1'b0;
      scan.rom_address      <= '0;
      scan.rom_read_ena     <= 1'b0;
      scan.pll_configupdate <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
    end else begin
      tmo                   <= sat_inc(tmo);
      done                  <= 1'b0;
      scan.pll_configupdate <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo <= '0;
          // A start landing on the done cycle belongs to the finished operation.
          if (start && !done) begin
            error             <= 1'b0;
            reconf_lat        <= 1'b0;
            scan.rom_address  <= '0;
            scan.rom_read_ena <= 1'b1;
            state             <= ST_READ;
          end
        end
        ST_READ: begin
          if (scan.rom_address == LAST_ADDR) begin
            scan.rom_read_ena <= 1'b0;
            state             <= ST_DRAIN;
            tmo               <= '0;
          end else begin
            scan.rom_address <= scan.rom_address + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (scan.rom_reconfig) reconf_lat <= 1'b1;
          if (!(|vld_p)) begin
            state <= ST_WAIT_RECONF;
            tmo   <= '0;
          end
        end
        ST_WAIT_RECONF: begin
          if (scan.rom_reconfig || reconf_lat) begin
            reconf_lat            <= 1'b0;
            scan.pll_configupdate <= 1'b1;
            state                 <= ST_UPDATE;
            tmo                   <= '0;
          end else if (tmo == RECONF_LAST) begin
            error <= 1'b1;
            state <= ST_IDLE;
            tmo   <= '0;
          end
        end
        ST_UPDATE: begin
          state <= ST_WAIT_DONE;
          tmo   <= '0;
        end
        ST_WAIT_DONE: begin
          if (scan.pll_scandone && !scandone_q) begin
            state <= ST_WAIT_LOCK;
            tmo   <= '0;
          end else if (tmo == DONE_LAST) begin
            error <= 1'b1;
            state <= ST_IDLE;
            tmo   <= '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (scan.pll_locked) begin
            done  <= 1'b1;
            state <= ST_IDLE;
            tmo   <= '0;
          end else if (tmo == DONE_LAST) begin
            error <= 1'b1;
            state <= ST_IDLE;
            tmo   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          tmo   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_scan_loader.md
PLL_SCAN_LOADER -- requirements
Module: pll_scan_loader

Interface
REQ-001 Parameter SCAN_BITS, default 144, is the number of PLL scan-chain bits read and shifted per reconfiguration; legal range 1..256.
REQ-002 Parameter ROM_LATENCY, default 2, is the number of clock cycles from rom_address/rom_read_ena to valid rom_q.
REQ-003 Parameter DONE_TIMEOUT, default 255, is the maximum number of cycles to wait for pll_scandone or pll_locked.
REQ-004 Port clock, input, 1: single clock for all logic; pll_scanclk is tied to clock at top level.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: one-cycle request to load and apply a PLL configuration, normally driven by the ROM trigger_read pulse.
REQ-007 Port rom_address, output, 8: scan-bit address presented to the config ROM.
REQ-008 Port rom_read_ena, output, 1: ROM read enable, high while addresses are issued.
REQ-009 Port rom_q, input, 1: serial scan bit returned by the ROM, ROM_LATENCY cycles after its address.
REQ-010 Port rom_reconfig, input, 1: one-cycle reconfig pulse from the ROM.
REQ-011 Port pll_scandata, output, 1: serial data into the PLL scan chain.
REQ-012 Port pll_scanclkena, output, 1: PLL scan clock enable; one bit is shifted per high cycle.
REQ-013 Port pll_configupdate, output, 1: one-cycle pulse applying the shifted configuration.
REQ-014 Port pll_scandone, input, 1: PLL reports that the update is complete.
REQ-015 Port pll_locked, input, 1: PLL lock indicator.
REQ-016 Port busy, output, 1: high in every state except IDLE.
REQ-017 Port done, output, 1: one-cycle pulse on successful completion.
REQ-018 Port error, output, 1: sticky timeout flag.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, DRAIN, WAIT_RECONF, UPDATE, WAIT_DONE and WAIT_LOCK.
REQ-020 IDLE: when start is high, the block SHALL clear error, zero the address counter and go to READ; start SHALL be ignored in every other state.
REQ-021 READ: rom_read_ena SHALL be high for exactly SCAN_BITS consecutive cycles with rom_address = 0, 1, ..., SCAN_BITS-1, then go to DRAIN.
REQ-022 A rom_read_ena delay line of depth ROM_LATENCY+1 SHALL drive pll_scanclkena, and pll_scandata SHALL be rom_q registered, so that the bit for address k is presented with pll_scanclkena high exactly ROM_LATENCY+1 cycles after address k is issued.
REQ-023 pll_scanclkena SHALL be high for exactly SCAN_BITS cycles per operation, with no gaps.
REQ-024 DRAIN: the block SHALL stay in DRAIN until the delay line is empty, then go to WAIT_RECONF.
REQ-025 WAIT_RECONF: on rom_reconfig the block SHALL go to UPDATE; if rom_reconfig already pulsed during DRAIN, it SHALL be latched and honoured; after 16 cycles with no pulse the block SHALL set error and return to IDLE.
REQ-026 UPDATE: pll_configupdate SHALL be high for exactly one cycle, then the block SHALL go to WAIT_DONE.
REQ-027 WAIT_DONE: on a rising edge of pll_scandone the block SHALL go to WAIT_LOCK; after DONE_TIMEOUT cycles the block SHALL set error and go to IDLE.
REQ-028 WAIT_LOCK: when pll_locked is high the block SHALL pulse done and go to IDLE; after DONE_TIMEOUT cycles the block SHALL set error and go to IDLE without pulsing done.
REQ-029 The timeout counter SHALL be 8 bits, SHALL clear on every state entry and SHALL saturate, never wrap.
REQ-030 The address counter SHALL be 8 bits; with SCAN_BITS=256 it SHALL end at 255 without wrapping to re-issue 0.
REQ-031 A start pulse coinciding with the done pulse SHALL be ignored.

Reset
REQ-032 While reset_n is low, the FSM SHALL be in IDLE, all outputs SHALL be 0, and the counters, delay line and reconfig latch SHALL be cleared.
REQ-033 Reset asserted mid-operation SHALL abort immediately, with no further pll_scanclkena or pll_configupdate cycles, and the next start SHALL restart from address 0.

Structure
REQ-034 The FSM state enum, the default SCAN_BITS, the reconfig timeout of 16 and the default DONE_TIMEOUT SHALL live in the shared package pll_scan_pkg.
REQ-035 No sub-module is required; the delay line SHALL be inline and parameterised by ROM_LATENCY.

Verification
REQ-036 Scenario: start with SCAN_BITS=144, ROM_LATENCY=2 and an alternating-bit ROM model -> rom_read_ena high for 144 cycles; pll_scanclkena high for 144 cycles starting 3 cycles later; pll_scandata matches the ROM pattern bit-exactly.
REQ-037 Scenario: the ROM model pulses rom_reconfig 3 cycles after rom_read_ena falls, pll_scandone rises 10 cycles after configupdate, pll_locked rises 5 cycles later -> one configupdate pulse, then done one cycle after lock, busy low, error 0.
REQ-038 Scenario: pll_scandone never rises -> error=1 exactly DONE_TIMEOUT (255) cycles after entering WAIT_DONE, no done pulse, and the next start clears error.
REQ-039 Scenario: start pulses repeatedly during READ -> exactly one scan sequence of 144 bits, no address restart.
REQ-040 Scenario: reset_n asserted at address 70 -> all outputs 0 within the same cycle; a later start issues address 0 and a full 144-bit sequence.
REQ-041 Scenario: SCAN_BITS=256 -> addresses 0..255 each issued once, no wrap, 256 scanclkena cycles.
